// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: pulls one- or two-byte instructions from a
// synchronous program ROM, presents them to execution and applies jumps/branches.
module ifetch_seq #(
  parameter int PM_AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PM_AW-1:0] pm_addr,
  input  logic [7:0]       pm_data,
  output logic [3:0]       opcode,
  output logic [7:0]       ir,
  output logic [7:0]       operand,
  output logic [PM_AW-1:0] pc,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             branch,
  input  logic             cond,
  input  logic             ijump,
  output logic             halted
);

  localparam logic [2:0] FETCH_OP  = 3'd0;
  localparam logic [2:0] LOAD_OP   = 3'd1;
  localparam logic [2:0] FETCH_ARG = 3'd2;
  localparam logic [2:0] LOAD_ARG  = 3'd3;
  localparam logic [2:0] READY     = 3'd4;
  localparam logic [2:0] HALT      = 3'd5;

  localparam logic [PM_AW-1:0] PC_ONE = {{(PM_AW-1){1'b0}}, 1'b1};

  logic [2:0]       r_state;
  logic [PM_AW-1:0] r_pc;
  logic [7:0]       r_ir;
  logic [7:0]       r_operand;
  logic [PM_AW-1:0] w_target;
  logic             w_take;

  // Jump target comes from the operand byte, zero-extended for wide memories.
  generate
    if (PM_AW <= 8) begin : g_narrow
      assign w_target = r_operand[PM_AW-1:0];
    end else begin : g_wide
      assign w_target = {{(PM_AW-8){1'b0}}, r_operand};
    end
  endgenerate

  assign w_take = ijump | (branch & cond);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH_OP;
      r_pc      <= '0;
      r_ir      <= 8'h00;
      r_operand <= 8'h00;
    end else begin
      case (r_state)
        FETCH_OP: r_state <= LOAD_OP;
        LOAD_OP: begin
          r_ir <= pm_data;
          r_pc <= r_pc + PC_ONE;
          if (pm_data[7:4] == 4'hF) begin
            r_state <= HALT;
          end else if (pm_data[3]) begin
            r_state <= FETCH_ARG;
          end else begin
            r_operand <= 8'h00;
            r_state   <= READY;
          end
        end
        FETCH_ARG: r_state <= LOAD_ARG;
        LOAD_ARG: begin
          r_operand <= pm_data;
          r_pc      <= r_pc + PC_ONE;
          r_state   <= READY;
        end
        READY: begin
          // Control inputs only matter in the cycle execution completes.
          if (exec_done) begin
            if (w_take) begin
              r_pc <= w_target;
            end
            r_state <= FETCH_OP;
          end
        end
        HALT:    r_state <= HALT;
        default: r_state <= FETCH_OP;
      endcase
    end
  end

  assign pm_addr     = r_pc;
  assign pc          = r_pc;
  assign ir          = r_ir;
  assign opcode      = r_ir[7:4];
  assign operand     = r_operand;
  assign instr_valid = (r_state == READY);
  assign halted      = (r_state == HALT);

endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq: latency, jumps/branches, hold in READY,
// pc wrap, HALT and asynchronous reset behaviour.
module tb_ifetch_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pm_addr;
  logic [7:0] pm_data = 8'h00;
  logic [3:0] opcode;
  logic [7:0] ir;
  logic [7:0] operand;
  logic [7:0] pc;
  logic       instr_valid;
  logic       exec_done = 1'b0;
  logic       branch = 1'b0;
  logic       cond = 1'b0;
  logic       ijump = 1'b0;
  logic       halted;

  logic [7:0] rom [0:255];

  int n_total = 0;
  int n_bad   = 0;

  ifetch_seq #(.PM_AW(8)) dut (
    .clk(clk), .rst(rst), .pm_addr(pm_addr), .pm_data(pm_data),
    .opcode(opcode), .ir(ir), .operand(operand), .pc(pc),
    .instr_valid(instr_valid), .exec_done(exec_done), .branch(branch),
    .cond(cond), .ijump(ijump), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM: data follows the address by one clock.
  always @(posedge clk) pm_data <= rom[pm_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  // Assert reset between edges, check the asynchronous clear, release on a negedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_rst_pc"}, pc, 8'h00);
    chk({tag, "_rst_ir"}, ir, 8'h00);
    chk({tag, "_rst_opcode"}, opcode, 4'h0);
    chk({tag, "_rst_operand"}, operand, 8'h00);
    chk({tag, "_rst_valid"}, instr_valid, 1'b0);
    chk({tag, "_rst_halted"}, halted, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts clocks until instr_valid, bounded, and checks the latency.
  task automatic wait_valid(input string tag, input int exp_cycles);
    int cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (instr_valid) break;
    end
    chk({tag, "_latency"}, cnt, exp_cycles);
  endtask

  task automatic pulse_done();
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
  endtask

  initial begin
    logic stable;

    // Single-byte instruction with exec_done held high.
    rom_clear();
    rom[0] = 8'h10;
    exec_done = 1'b1;
    do_reset("t1");
    chk("t1_opcode_after_rst", opcode, 4'h0);
    chk("t1_pm_addr_after_rst", pm_addr, 8'h00);
    wait_valid("t1", 2);
    chk("t1_opcode", opcode, 4'h1);
    chk("t1_operand", operand, 8'h00);
    chk("t1_pc", pc, 8'h01);
    @(negedge clk);
    chk("t1_fetch_valid", instr_valid, 1'b0);
    chk("t1_fetch_addr", pm_addr, 8'h01);
    wait_valid("t1b", 2);
    chk("t1b_pc", pc, 8'h02);
    chk("t1b_ir", ir, 8'h00);
    exec_done = 1'b0;
    $display("t1 one-byte fetch done");

    // Two-byte instruction then unconditional jump; ijump held through fetch.
    rom_clear();
    rom[0] = 8'h88; rom[1] = 8'h20; rom[8'h20] = 8'h30;
    ijump = 1'b1;
    do_reset("t2");
    wait_valid("t2", 4);
    chk("t2_ir", ir, 8'h88);
    chk("t2_opcode", opcode, 4'h8);
    chk("t2_operand", operand, 8'h20);
    chk("t2_pc", pc, 8'h02);
    pulse_done();
    ijump = 1'b0;
    chk("t2_jump_addr", pm_addr, 8'h20);
    chk("t2_jump_valid", instr_valid, 1'b0);
    wait_valid("t2b", 2);
    chk("t2b_ir", ir, 8'h30);
    chk("t2b_operand", operand, 8'h00);
    chk("t2b_pc", pc, 8'h21);
    $display("t2 jump done");

    // Conditional branch, not taken then taken.
    rom_clear();
    rom[0] = 8'h98; rom[1] = 8'h40;
    do_reset("t3a");
    wait_valid("t3a", 4);
    branch = 1'b1; cond = 1'b0;
    pulse_done();
    branch = 1'b0;
    chk("t3a_fallthrough_addr", pm_addr, 8'h02);
    do_reset("t3b");
    wait_valid("t3b", 4);
    branch = 1'b1; cond = 1'b1;
    pulse_done();
    branch = 1'b0; cond = 1'b0;
    chk("t3b_taken_addr", pm_addr, 8'h40);
    // ijump wins even when the branch condition is false.
    do_reset("t3c");
    wait_valid("t3c", 4);
    ijump = 1'b1; branch = 1'b1; cond = 1'b0;
    pulse_done();
    ijump = 1'b0; branch = 1'b0;
    chk("t3c_priority_addr", pm_addr, 8'h40);
    $display("t3 branch done");

    // Hold in READY while exec_done is low.
    rom_clear();
    rom[0] = 8'h10;
    do_reset("t4");
    wait_valid("t4", 2);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!instr_valid || ir !== 8'h10 || pc !== 8'h01 || operand !== 8'h00) stable = 1'b0;
    end
    chk("t4_hold_stable", stable, 1'b1);
    pulse_done();
    chk("t4_leave_valid", instr_valid, 1'b0);
    chk("t4_leave_addr", pm_addr, 8'h01);
    $display("t4 ready hold done");

    // pc wrap from 0xFF, then HALT.
    rom_clear();
    rom[0] = 8'h88; rom[1] = 8'hFF; rom[8'hFF] = 8'h10;
    do_reset("t5");
    wait_valid("t5", 4);
    ijump = 1'b1;
    pulse_done();
    ijump = 1'b0;
    chk("t5_jump_addr", pm_addr, 8'hFF);
    wait_valid("t5b", 2);
    chk("t5_wrap_pc", pc, 8'h00);
    chk("t5_wrap_ir", ir, 8'h10);
    rom[0] = 8'hF0;
    pulse_done();
    @(negedge clk);
    @(negedge clk);
    chk("t5_halted", halted, 1'b1);
    chk("t5_halt_valid", instr_valid, 1'b0);
    chk("t5_halt_pc", pc, 8'h01);
    exec_done = 1'b1; ijump = 1'b1;
    repeat (5) @(negedge clk);
    exec_done = 1'b0; ijump = 1'b0;
    chk("t5_halt_stay", halted, 1'b1);
    chk("t5_halt_pc_frozen", pc, 8'h01);
    chk("t5_halt_ir_frozen", ir, 8'hF0);
    $display("t5 wrap and halt done");

    // Reset asserted while in LOAD_ARG.
    rom_clear();
    rom[0] = 8'h88; rom[1] = 8'h55;
    do_reset("t6");
    repeat (3) @(negedge clk);
    chk("t6_pre_ir", ir, 8'h88);
    chk("t6_pre_pc", pc, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("t6_clr_pc", pc, 8'h00);
    chk("t6_clr_ir", ir, 8'h00);
    chk("t6_clr_opcode", opcode, 4'h0);
    chk("t6_clr_operand", operand, 8'h00);
    chk("t6_clr_valid", instr_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_restart_addr", pm_addr, 8'h00);
    wait_valid("t6", 4);
    chk("t6_operand", operand, 8'h55);
    $display("t6 reset in LOAD_ARG done");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
